shift_register: RTL and testbench
=================================

# shift_register

Registered constant left shifter for the MIPS datapath. Each rising clock edge captures a 32-bit word, shifts it left by a fixed amount (default 2, word-to-byte offset scaling) and holds the result on the output. It sits between the sign-extend unit and the branch-target adder, which gives that path a one-cycle, glitch-free registered boundary.

## Interface
Parameters:
- WIDTH, 32, data width in bits; legal range ≥ 2.
- SHIFT, 2, constant left-shift amount; legal range 0 ≤ SHIFT < WIDTH.

Ports:
- CLK, input, 1, sole clock; all state updates on the rising edge.
- nRST, input, 1, reset, synchronous and active-low; sampled on the CLK rising edge.
- dataIn, input, WIDTH, word to be shifted.
- dataOut, output, WIDTH, registered result of dataIn << SHIFT.
- ovf, output, 1, registered overflow flag. Present only when SHIFT_REGISTER_OVF_EN is defined.

## Operation
- Rising edge with nRST=0:
  - dataOut ← 0.
  - ovf ← 0 (if present).
  - dataIn is ignored.
- Rising edge with nRST=1:
  - dataOut ← {dataIn[WIDTH-1-SHIFT:0], SHIFT zero bits}.
  - The upper SHIFT bits of dataIn are discarded; the lower SHIFT bits of the result are always 0.
- Logical shift only. There is no sign preservation and no rotate.
- SHIFT=0 degenerates to a plain WIDTH-bit register.
- No enable input: the register loads on every non-reset edge.
- Output is driven only from flops. There is no combinational path from dataIn to dataOut.
- X on dataIn while nRST=0 must not propagate; dataOut stays 0.

## Timing
- Latency: exactly 1 cycle. A value present at edge N appears on dataOut after edge N and holds until edge N+1.
- Throughput: one word per cycle.
- Power-up value before the first reset edge is unspecified. After one edge with nRST=0, dataOut=0.
- Reset asserted mid-stream: the next edge clears the output regardless of dataIn. The first edge with nRST=1 loads the shifted dataIn sampled at that edge.
- dataIn changes between edges have no effect on the output.

## Configuration
- Macro: SHIFT_REGISTER_OVF_EN.
- Defined:
  - The ovf port exists.
  - On each non-reset edge, ovf ← |dataIn[WIDTH-1:WIDTH-SHIFT], i.e. 1 when any nonzero bit is shifted out.
  - ovf ← 0 on reset.
  - When SHIFT=0, ovf is constant 0.
- Undefined:
  - The ovf port and its flop are absent.
  - dataOut behaviour is identical in both builds.

## Structure
- Shared package (cpu_pkg) holds:
  - the datapath width constant DATA_W = 32;
  - the default shift constant BRANCH_SHIFT = 2.
  - The module's parameter defaults take these constants.
- One sub-module is natural: shl_const, a purely combinational WIDTH/SHIFT constant left shifter that also produces the lost-bits OR term.
- The top-level module holds only the flops, the reset mux and the conditional ovf.

## Test plan
All cases use WIDTH=32, SHIFT=2, 100 ns clock.
- Reset: nRST=0 for one edge with dataIn=32'hDEADBEEF -> dataOut=0, ovf=0.
- Basic stream (nRST=1): dataIn=32'h0001 at edge 1, 32'hFFFF at edge 2, 32'h00FF at edge 3 -> dataOut after each edge is 32'h4, then 32'h3FFFC, then 32'h3FC.
- Lost bits: dataIn=32'hC000_0001 -> dataOut=32'h0000_0004; ovf=1 (OVF build).
- Boundary: dataIn=32'hFFFF_FFFF -> dataOut=32'hFFFF_FFFC, ovf=1. Then dataIn=32'h3FFF_FFFF -> dataOut=32'hFFFF_FFFC, ovf=0.
- Mid-stream reset: nRST=0 for one edge while dataIn=32'h1234 -> dataOut=0. Release with dataIn=32'h1234 -> next edge dataOut=32'h48D0.
- Glitch immunity: toggle dataIn between edges -> dataOut changes only at rising edges. SHIFT=0 variant: dataIn=32'hA5 -> dataOut=32'hA5.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath-wide constants shared by the MIPS datapath blocks.
`default_nettype none

package cpu_pkg;

    localparam int DATA_W       = 32;
    localparam int BRANCH_SHIFT = 2;

endpackage

`default_nettype wire

// File: rtl/shl_const.sv
// ----------------------------------------------------------------------------
// shl_const: combinational constant left shifter; with SHIFT_REGISTER_OVF_EN
// defined it also reports whether any set bit was shifted out. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shl_const
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SHIFT = BRANCH_SHIFT
) (
    input  logic [WIDTH-1:0] data_i,
`ifdef SHIFT_REGISTER_OVF_EN
    output logic             lost_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    assign data_o = data_i << SHIFT;

`ifdef SHIFT_REGISTER_OVF_EN
    generate
        if (SHIFT == 0) begin : g_no_lost
            assign lost_o = 1'b0;
        end else begin : g_lost
            assign lost_o = |data_i[WIDTH-1:WIDTH-SHIFT];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: rtl/shift_register.sv
// ----------------------------------------------------------------------------
// shift_register: registered constant left shifter (dataOut = dataIn << SHIFT,
// one-cycle latency). Optional ovf flag under SHIFT_REGISTER_OVF_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_register
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SHIFT = BRANCH_SHIFT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] dataIn,
`ifdef SHIFT_REGISTER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] dataOut
);

    logic [WIDTH-1:0] dataOut_d;
    logic [WIDTH-1:0] dataOut_q;

`ifdef SHIFT_REGISTER_OVF_EN
    logic ovf_d;
    logic ovf_q;
`endif

    shl_const #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_shl (
        .data_i (dataIn),
`ifdef SHIFT_REGISTER_OVF_EN
        .lost_o (ovf_d),
`endif
        .data_o (dataOut_d)
    );

    // Reset branch ignores dataIn entirely, so unknowns cannot leak out
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            dataOut_q <= '0;
        end else begin
            dataOut_q <= dataOut_d;
        end
    end

    assign dataOut = dataOut_q;

`ifdef SHIFT_REGISTER_OVF_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_register.sv
// tb_shift_register: directed and random checks of shift_register (SHIFT=2 and SHIFT=0)
// against an arithmetic model (multiply by 2**SHIFT, modulo 2**WIDTH).
`default_nettype none

module tb_shift_register;

    localparam int W = 32;
    localparam int S = 2;

    logic         CLK = 1'b0;
    logic         nRST;
    logic [W-1:0] dataIn;
    wire  [W-1:0] dataOut;
    wire  [W-1:0] dataOut0;
`ifdef SHIFT_REGISTER_OVF_EN
    wire          ovf;
    wire          ovf0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #50 CLK = ~CLK;

    shift_register #(.WIDTH(W), .SHIFT(S)) u_dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .dataIn  (dataIn),
`ifdef SHIFT_REGISTER_OVF_EN
        .ovf     (ovf),
`endif
        .dataOut (dataOut)
    );

    shift_register #(.WIDTH(W), .SHIFT(0)) u_dut0 (
        .CLK     (CLK),
        .nRST    (nRST),
        .dataIn  (dataIn),
`ifdef SHIFT_REGISTER_OVF_EN
        .ovf     (ovf0),
`endif
        .dataOut (dataOut0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Left shift modelled as multiplication by 2**s, truncated to W bits
    function automatic logic [W-1:0] model_out(input logic [W-1:0] d, input int s);
        logic [63:0] prod;
        prod = 64'(d) * (64'd1 << s);
        return prod[W-1:0];
    endfunction

    // Overflow whenever the value no longer fits in W-s bits
    function automatic logic model_ovf(input logic [W-1:0] d, input int s);
        return 64'(d) >= (64'd1 << (W - s));
    endfunction

    task automatic step(input logic rst_n, input logic [W-1:0] d, input string tag);
        nRST   = rst_n;
        dataIn = d;
        @(posedge CLK);
        #1;
        check(tag, 64'(dataOut), rst_n ? 64'(model_out(d, S)) : 64'd0);
        check({tag, "_s0"}, 64'(dataOut0), rst_n ? 64'(model_out(d, 0)) : 64'd0);
`ifdef SHIFT_REGISTER_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), rst_n ? 64'(model_ovf(d, S)) : 64'd0);
        check({tag, "_ovf_s0"}, 64'(ovf0), rst_n ? 64'(model_ovf(d, 0)) : 64'd0);
`endif
    endtask

    initial begin
        nRST   = 1'b0;
        dataIn = 32'hDEAD_BEEF;

        step(1'b0, 32'hDEAD_BEEF, "reset");
        step(1'b1, 32'h0000_0001, "stream1");
        check("stream1_lit", 64'(dataOut), 64'h4);
        step(1'b1, 32'h0000_FFFF, "stream2");
        check("stream2_lit", 64'(dataOut), 64'h3FFFC);
        step(1'b1, 32'h0000_00FF, "stream3");
        check("stream3_lit", 64'(dataOut), 64'h3FC);
        step(1'b1, 32'hC000_0001, "lost_bits");
        check("lost_bits_lit", 64'(dataOut), 64'h4);
        step(1'b1, 32'hFFFF_FFFF, "all_ones");
        check("all_ones_lit", 64'(dataOut), 64'hFFFF_FFFC);
        step(1'b1, 32'h3FFF_FFFF, "no_ovf_max");
        check("no_ovf_max_lit", 64'(dataOut), 64'hFFFF_FFFC);
        step(1'b1, 32'h4000_0000, "top_single");
        step(1'b0, 32'h1234, "mid_reset");
        step(1'b1, 32'h1234, "release");
        check("release_lit", 64'(dataOut), 64'h48D0);

        // Input toggles between edges must not reach the output
        #10 dataIn = 32'hFFFF_FFFF;
        #10 dataIn = 32'h0;
        #10 dataIn = 32'h0000_5555;
        check("glitch_hold", 64'(dataOut), 64'h48D0);
        check("glitch_hold_s0", 64'(dataOut0), 64'h1234);
        @(posedge CLK);
        #1;
        check("glitch_load", 64'(dataOut), 64'h15554);

        step(1'b1, 32'h0000_00A5, "shift0");
        check("shift0_lit", 64'(dataOut0), 64'hA5);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] d;
            logic         r;
            d = $urandom;
            if ((i % 5) == 0) d = d | 32'hC000_0000;
            if ((i % 7) == 0) d = d & 32'h3FFF_FFFF;
            r = ($urandom_range(0, 7) != 0);
            step(r, d, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
